weight_sign_bank_read_ctrl: RTL and testbench

WEIGHT_SIGN_BANK_READ_CTRL -- requirements
Module: weight_sign_bank_read_ctrl

---
 rtl/weight_sign_pkg.sv | 23 ++
 rtl/weight_sign_bank_ram.sv | 56 +++++
 rtl/weight_sign_bank_read_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_weight_sign_bank_read_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/weight_sign_pkg.sv
// Shared definitions for the weight/sign bank buffer.
// Holds the per-bank state encoding, the err flag bit positions and a small
// helper that tells whether a bank currently holds data awaiting consumption.
package weight_sign_pkg;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2,
    BANK_READING = 2'd3
  } bank_state_e;

  localparam int unsigned ERR_W            = 3;
  localparam int unsigned ERR_CFG_ZERO     = 0;
  localparam int unsigned ERR_EARLY_LAST   = 1;
  localparam int unsigned ERR_MISSING_LAST = 2;

  // A bank that is FULL or READING must not be overwritten.
  function automatic logic holds_data(input bank_state_e s);
    return (s == BANK_FULL) || (s == BANK_READING);
  endfunction

endpackage

// File: rtl/weight_sign_bank_ram.sv
// Row-organised bank storage.
// ROW independent row memories, each NUM_BANK*2^ADDR_W words of DW bits.
// One write port (a single row word per cycle) and one registered read port
// returning all ROW words of an address at once, row 0 in the LSBs.
// No reset: contents and read register are undefined until written.
//
// Ports:
//   clk      clock
//   wr_en    write strobe
//   wr_bank  bank of the written word
//   wr_addr  row address inside the bank
//   wr_row   which row memory receives wr_data
//   wr_data  DW-bit word
//   rd_en    read strobe (read register holds when low)
//   rd_bank  bank to read
//   rd_addr  row address to read
//   rd_data  DW*ROW concatenated read data, valid one cycle after rd_en
module weight_sign_bank_ram #(
  parameter int unsigned NUM_BANK = 2,
  parameter int unsigned ROW      = 32,
  parameter int unsigned DW       = 64,
  parameter int unsigned ADDR_W   = 11,
  localparam int unsigned BANK_W  = $clog2(NUM_BANK),
  localparam int unsigned ROW_W   = $clog2(ROW)
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [BANK_W-1:0]    wr_bank,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [ROW_W-1:0]     wr_row,
  input  logic [DW-1:0]        wr_data,
  input  logic                 rd_en,
  input  logic [BANK_W-1:0]    rd_bank,
  input  logic [ADDR_W-1:0]    rd_addr,
  output logic [DW*ROW-1:0]    rd_data
);

  localparam int unsigned DEPTH = NUM_BANK << ADDR_W;

  for (genvar r = 0; r < ROW; r++) begin : g_row
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] q;

    always_ff @(posedge clk) begin
      if (wr_en && (wr_row == ROW_W'(r))) begin
        mem[{wr_bank, wr_addr}] <= wr_data;
      end
      if (rd_en) begin
        q <= mem[{rd_bank, rd_addr}];
      end
    end

    assign rd_data[r*DW +: DW] = q;
  end

endmodule

// File: rtl/weight_sign_bank_read_ctrl.sv
// Multi-bank ping-pong buffer controller for weight/sign data.
// A config handshake allocates the next empty bank, an AXI-Stream slave fills
// it one row word per beat, and the consumer then reads the bank cfg_reps
// times over cfg_words addresses, all ROW words per address in one cycle.
// Fill and read run concurrently on different banks in round-robin order.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   sys_start           synchronous clear of all control state (RAM and err kept)
//   cfg_valid/ready     config handshake; cfg_words, cfg_reps latched per bank
//   s_axis_*            AXI-Stream slave carrying DW-bit row words
//   rd_en               consumer read request
//   dout, dout_valid    read data (row 0 in LSBs), valid one cycle after a read
//   bank_full           per-bank flag, set while FULL or READING
//   read_done           one-cycle pulse with the dout of the releasing read
//   err                 sticky: [0] zero config, [1] early tlast, [2] missing tlast
module weight_sign_bank_read_ctrl
  import weight_sign_pkg::*;
#(
  parameter int unsigned NUM_BANK = 2,
  parameter int unsigned ROW      = 32,
  parameter int unsigned DW       = 64,
  parameter int unsigned ADDR_W   = 11,
  parameter int unsigned REP_W    = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sys_start,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [ADDR_W-1:0]    cfg_words,
  input  logic [REP_W-1:0]     cfg_reps,
  input  logic [DW-1:0]        s_axis_tdata,
  input  logic                 s_axis_tvalid,
  input  logic                 s_axis_tlast,
  output logic                 s_axis_tready,
  input  logic                 rd_en,
  output logic [DW*ROW-1:0]    dout,
  output logic                 dout_valid,
  output logic [NUM_BANK-1:0]  bank_full,
  output logic                 read_done,
  output logic [ERR_W-1:0]     err
);

  localparam int unsigned BANK_W = $clog2(NUM_BANK);
  localparam int unsigned ROW_W  = $clog2(ROW);
  localparam int unsigned BEAT_W = ADDR_W + ROW_W;

  bank_state_e          st      [NUM_BANK];
  bank_state_e          st_n    [NUM_BANK];
  logic [ADDR_W-1:0]    words_q [NUM_BANK];
  logic [REP_W-1:0]     reps_q  [NUM_BANK];

  logic [BANK_W-1:0]    wb, wb_n;
  logic [BANK_W-1:0]    rb, rb_n;
  logic [BEAT_W-1:0]    beat, beat_n;
  logic [ADDR_W-1:0]    raddr, raddr_n;
  logic [REP_W-1:0]     rep, rep_n;
  logic [ERR_W-1:0]     err_q, err_n;
  logic                 dv_q;
  logic                 done_q;

  logic [NUM_BANK-1:0]  filling;
  logic                 fill_active;
  logic                 cfg_fire;
  logic                 cfg_zero;
  logic                 beat_fire;
  logic                 beat_end;
  logic                 rd_fire;
  logic                 rd_wrap;
  logic                 rd_final;

  function automatic logic [BANK_W-1:0] next_bank(input logic [BANK_W-1:0] b);
    return (b == BANK_W'(NUM_BANK - 1)) ? '0 : b + BANK_W'(1);
  endfunction

  for (genvar i = 0; i < NUM_BANK; i++) begin : g_bank_flags
    assign filling[i]   = (st[i] == BANK_FILLING);
    assign bank_full[i] = holds_data(st[i]);
  end

  assign fill_active   = |filling;
  assign cfg_ready     = (st[wb] == BANK_EMPTY) && !fill_active;
  assign s_axis_tready = (st[wb] == BANK_FILLING);

  assign cfg_fire  = cfg_valid && cfg_ready;
  assign cfg_zero  = (cfg_words == '0) || (cfg_reps == '0);
  assign beat_fire = s_axis_tvalid && s_axis_tready;

  // Last beat of a fill is words*ROW-1: address field words-1, row field all ones.
  assign beat_end  = (beat == {words_q[wb] - ADDR_W'(1), {ROW_W{1'b1}}});

  assign rd_fire   = rd_en && (st[rb] == BANK_READING);
  assign rd_wrap   = (raddr == words_q[rb] - ADDR_W'(1));
  assign rd_final  = rd_wrap && (rep == reps_q[rb] - REP_W'(1));

  always_comb begin
    st_n    = st;
    wb_n    = wb;
    rb_n    = rb;
    beat_n  = beat;
    raddr_n = raddr;
    rep_n   = rep;
    err_n   = err_q;

    if (cfg_fire) begin
      if (cfg_zero) begin
        err_n[ERR_CFG_ZERO] = 1'b1;
      end else begin
        st_n[wb] = BANK_FILLING;
      end
    end

    if (beat_fire) begin
      if (beat_end || s_axis_tlast) begin
        st_n[wb] = BANK_FULL;
        wb_n     = next_bank(wb);
        beat_n   = '0;
        if (!beat_end) begin
          err_n[ERR_EARLY_LAST] = 1'b1;
        end
        if (beat_end && !s_axis_tlast) begin
          err_n[ERR_MISSING_LAST] = 1'b1;
        end
      end else begin
        beat_n = beat + BEAT_W'(1);
      end
    end

    if (st[rb] == BANK_FULL) begin
      st_n[rb] = BANK_READING;
    end

    if (rd_fire) begin
      if (rd_wrap) begin
        raddr_n = '0;
        if (rd_final) begin
          st_n[rb] = BANK_EMPTY;
          rb_n     = next_bank(rb);
          rep_n    = '0;
        end else begin
          rep_n = rep + REP_W'(1);
        end
      end else begin
        raddr_n = raddr + ADDR_W'(1);
      end
    end

    // Clear overrides every transfer in flight but keeps the sticky errors.
    if (sys_start) begin
      st_n    = '{default: BANK_EMPTY};
      wb_n    = '0;
      rb_n    = '0;
      beat_n  = '0;
      raddr_n = '0;
      rep_n   = '0;
      err_n   = err_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st      <= '{default: BANK_EMPTY};
      words_q <= '{default: '0};
      reps_q  <= '{default: '0};
      wb      <= '0;
      rb      <= '0;
      beat    <= '0;
      raddr   <= '0;
      rep     <= '0;
      err_q   <= '0;
      dv_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      st     <= st_n;
      wb     <= wb_n;
      rb     <= rb_n;
      beat   <= beat_n;
      raddr  <= raddr_n;
      rep    <= rep_n;
      err_q  <= err_n;
      dv_q   <= rd_fire && !sys_start;
      done_q <= rd_fire && rd_final && !sys_start;
      if (cfg_fire && !cfg_zero && !sys_start) begin
        words_q[wb] <= cfg_words;
        reps_q[wb]  <= cfg_reps;
      end
    end
  end

  assign dout_valid = dv_q;
  assign read_done  = done_q;
  assign err        = err_q;

  weight_sign_bank_ram #(
    .NUM_BANK (NUM_BANK),
    .ROW      (ROW),
    .DW       (DW),
    .ADDR_W   (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (beat_fire && !sys_start),
    .wr_bank (wb),
    .wr_addr (beat[BEAT_W-1:ROW_W]),
    .wr_row  (beat[ROW_W-1:0]),
    .wr_data (s_axis_tdata),
    .rd_en   (rd_fire && !sys_start),
    .rd_bank (rb),
    .rd_addr (raddr),
    .rd_data (dout)
  );

endmodule

// File: tb/tb_weight_sign_bank_read_ctrl.sv
module tb_weight_sign_bank_read_ctrl;

  localparam int unsigned NUM_BANK = 2;
  localparam int unsigned ROW      = 32;
  localparam int unsigned DW       = 64;
  localparam int unsigned ADDR_W   = 11;
  localparam int unsigned REP_W    = 9;
  localparam int unsigned MAXW     = 4;

  logic                 clk;
  logic                 rst;
  logic                 sys_start;
  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [ADDR_W-1:0]    cfg_words;
  logic [REP_W-1:0]     cfg_reps;
  logic [DW-1:0]        s_axis_tdata;
  logic                 s_axis_tvalid;
  logic                 s_axis_tlast;
  logic                 s_axis_tready;
  logic                 rd_en;
  logic [DW*ROW-1:0]    dout;
  logic                 dout_valid;
  logic [NUM_BANK-1:0]  bank_full;
  logic                 read_done;
  logic [2:0]           err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  weight_sign_bank_read_ctrl #(
    .NUM_BANK (NUM_BANK),
    .ROW      (ROW),
    .DW       (DW),
    .ADDR_W   (ADDR_W),
    .REP_W    (REP_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .sys_start     (sys_start),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_words     (cfg_words),
    .cfg_reps      (cfg_reps),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .rd_en         (rd_en),
    .dout          (dout),
    .dout_valid    (dout_valid),
    .bank_full     (bank_full),
    .read_done     (read_done),
    .err           (err)
  );

  typedef struct {
    logic [DW*ROW-1:0] data;
    logic              done;
  } exp_t;

  exp_t              sbq [$];
  logic [DW*ROW-1:0] model [NUM_BANK][MAXW];
  int unsigned       exp_wb;
  int                n_checks = 0;
  int                n_errs   = 0;

  task automatic check(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic do_cfg(input int words, input int reps);
    int unsigned n;
    n = 0;
    cfg_words = ADDR_W'(words);
    cfg_reps  = REP_W'(reps);
    cfg_valid = 1'b1;
    while (!cfg_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cfg_ready) check("cfg_ready_wait", 64'(cfg_ready), 64'(1));
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic stream_beat(input int k, input bit last);
    logic [DW-1:0] d;
    int unsigned   n;
    d = {$urandom, $urandom};
    n = 0;
    s_axis_tdata  = d;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    while (!s_axis_tready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!s_axis_tready) check("tready_wait", 64'(s_axis_tready), 64'(1));
    else model[exp_wb][k / ROW][(k % ROW) * DW +: DW] = d;
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic load_bank(input int words, input int reps, input int nbeats, input int last_at);
    exp_t e;
    do_cfg(words, reps);
    for (int k = 0; k < nbeats; k++) stream_beat(k, k == last_at);
    for (int r = 0; r < reps; r++) begin
      for (int a = 0; a < words; a++) begin
        e.data = model[exp_wb][a];
        e.done = (r == reps - 1) && (a == words - 1);
        sbq.push_back(e);
      end
    end
    exp_wb = (exp_wb + 1) % NUM_BANK;
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while (sbq.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) check("drain_pending", 64'(sbq.size()), 64'(0));
  endtask

  task automatic pulse_sys_start();
    sys_start = 1'b1;
    @(negedge clk);
    sys_start = 1'b0;
    exp_wb = 0;
  endtask

  // Scoreboard consumer: every dout_valid pops one expected read.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (dout_valid) begin
        if (sbq.size() == 0) begin
          check("dout_valid_unexpected", 64'(dout_valid), 64'(0));
        end else begin
          e = sbq.pop_front();
          for (int r = 0; r < ROW; r++)
            check($sformatf("dout_row%0d", r), dout[r*DW +: DW], e.data[r*DW +: DW]);
          check("read_done", 64'(read_done), 64'(e.done));
        end
      end else if (read_done) begin
        check("read_done_without_dv", 64'(read_done), 64'(0));
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got time limit, expected completion");
    $fatal(1);
  end

  initial begin : main
    int n_dv, done_at, gap, seen, early;
    rst = 1'b1; sys_start = 1'b0; cfg_valid = 1'b0; cfg_words = '0; cfg_reps = '0;
    s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; rd_en = 1'b0;
    exp_wb = 0;

    #2;
    check("rst_cfg_ready",  64'(cfg_ready),     64'(1));
    check("rst_tready",     64'(s_axis_tready), 64'(0));
    check("rst_dout_valid", 64'(dout_valid),    64'(0));
    check("rst_read_done",  64'(read_done),     64'(0));
    check("rst_bank_full",  64'(bank_full),     64'(0));
    check("rst_err",        64'(err),           64'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // words=4 reps=2, rd_en held: 8 consecutive reads, done on the 8th
    rd_en = 1'b1;
    load_bank(4, 2, 128, 127);
    check("t1_bank_full", 64'(bank_full), 64'(2'b01));
    n_dv = 0; done_at = 0; gap = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (dout_valid) begin
        n_dv++;
        if (read_done) done_at = n_dv;
      end else if (n_dv > 0 && n_dv < 8) begin
        gap++;
      end
    end
    check("t1_dv_count", 64'(n_dv), 64'(8));
    check("t1_done_at",  64'(done_at), 64'(8));
    check("t1_dv_gap",   64'(gap), 64'(0));
    check("t1_err",      64'(err), 64'(0));
    check("t1_released", 64'(bank_full), 64'(0));
    drain();
    rd_en = 1'b0;

    // Both banks occupied: third config must wait for the first release
    pulse_sys_start();
    load_bank(2, 1, 64, 63);
    load_bank(2, 1, 64, 63);
    repeat (3) @(negedge clk);
    check("t2_cfg_ready_blocked", 64'(cfg_ready), 64'(0));
    check("t2_tready_blocked",    64'(s_axis_tready), 64'(0));
    check("t2_bank_full",         64'(bank_full), 64'(2'b11));
    rd_en = 1'b1;
    seen = 0; early = 0;
    for (int c = 0; c < 20 && seen == 0; c++) begin
      @(negedge clk);
      if (read_done) seen = 1;
      else if (cfg_ready) early = 1;
    end
    check("t2_read_done_seen",  64'(seen), 64'(1));
    check("t2_cfg_ready_early", 64'(early), 64'(0));
    check("t2_cfg_ready_after", 64'(cfg_ready), 64'(1));
    load_bank(2, 1, 64, 63);
    drain();
    rd_en = 1'b0;

    // Early tlast on beat 10 of a 64-beat fill
    pulse_sys_start();
    load_bank(2, 1, 11, 10);
    check("t3_err",       64'(err), 64'(3'b010));
    check("t3_bank_full", 64'(bank_full), 64'(2'b01));
    check("t3_tready",    64'(s_axis_tready), 64'(0));
    rd_en = 1'b1;
    drain();
    rd_en = 1'b0;

    // Zero-word config: handshake completes, nothing allocated
    do_cfg(0, 1);
    check("t4_err",       64'(err), 64'(3'b011));
    check("t4_bank_full", 64'(bank_full), 64'(0));
    check("t4_cfg_ready", 64'(cfg_ready), 64'(1));
    check("t4_tready",    64'(s_axis_tready), 64'(0));

    // sys_start while reading at addr 1
    load_bank(4, 1, 128, 127);
    @(negedge clk);
    rd_en = 1'b1;
    @(negedge clk);
    sys_start = 1'b1;
    @(negedge clk);
    sys_start = 1'b0;
    rd_en = 1'b0;
    exp_wb = 0;
    check("t5_dout_valid", 64'(dout_valid), 64'(0));
    check("t5_read_done",  64'(read_done), 64'(0));
    check("t5_bank_full",  64'(bank_full), 64'(0));
    check("t5_cfg_ready",  64'(cfg_ready), 64'(1));
    check("t5_err_kept",   64'(err), 64'(3'b011));
    sbq.delete();
    @(negedge clk);

    // Async reset between edges in the middle of a fill
    load_bank(1, 1, 32, 31);
    do_cfg(2, 1);
    for (int k = 0; k < 20; k++) stream_beat(k, 1'b0);
    check("t6_pre_bank_full", 64'(bank_full), 64'(2'b01));
    check("t6_pre_err",       64'(err), 64'(3'b011));
    #2;
    rst = 1'b1;
    #1;
    check("t6_cfg_ready",  64'(cfg_ready), 64'(1));
    check("t6_tready",     64'(s_axis_tready), 64'(0));
    check("t6_dout_valid", 64'(dout_valid), 64'(0));
    check("t6_read_done",  64'(read_done), 64'(0));
    check("t6_bank_full",  64'(bank_full), 64'(0));
    check("t6_err",        64'(err), 64'(0));
    sbq.delete();
    exp_wb = 0;
    @(negedge clk);
    rst = 1'b0;
    rd_en = 1'b1;
    load_bank(1, 1, 32, 31);
    drain();
    rd_en = 1'b0;
    check("t6_post_err", 64'(err), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
